// File: rtl/ryuki_datatypes.sv
// Shared trace datatypes for the ryuki pipeline trackers.
// trace_output is one instruction's trace element; each stage tracker fills in
// its own timing record and forwards the rest untouched.
package ryuki_datatypes;

  localparam int unsigned TraceAddrWidth = 32;
  localparam int unsigned TraceDataWidth = 32;

  typedef struct packed {
    logic signed [31:0] time_start;
    logic signed [31:0] time_end;
  } stage_times_t;

  typedef struct packed {
    logic signed [31:0] time_start;
    logic signed [31:0] time_end;
    logic               mem_access;
    logic signed [31:0] mem_gnt_time;
  } ex_times_t;

  typedef struct packed {
    logic [TraceAddrWidth-1:0] addr;
    logic [TraceDataWidth-1:0] data;
    logic                      pass_through;  // element skips EX timing
    stage_times_t              if_data;
    stage_times_t              id_data;
    ex_times_t                 ex_data;
    stage_times_t              wb_data;
  } trace_output;

  typedef enum logic [1:0] {
    EXECUTE_START,
    EXECUTE_END,
    MEM_WAIT
  } ex_state_e;

endpackage

// File: rtl/trace_fifo.sv
// Small circular queue of trace elements.
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   push, wdata   write request and element; accepted when not full or when
//                 a pop happens in the same cycle
//   pop           read request; ignored when empty
//   rdata         current head element (valid when !empty)
//   full, empty   occupancy flags
module trace_fifo #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter type         elem_t     = logic
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  push,
  input  elem_t wdata,
  input  logic  pop,
  output elem_t rdata,
  output logic  full,
  output logic  empty
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_depth_check
    $error("trace_fifo: FIFO_DEPTH must be a power of two and at least 2");
  end

  elem_t           mem_q [FIFO_DEPTH];
  logic [PtrW-1:0] wptr_q, rptr_q;
  logic [CntW-1:0] count_q;
  logic            do_push, do_pop;

  assign full    = (count_q == CntW'(FIFO_DEPTH));
  assign empty   = (count_q == '0);
  assign do_pop  = pop && !empty;
  // A simultaneous pop frees a slot, so a push into a full queue still lands.
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem_q[rptr_q];

  always_ff @(posedge clk) begin
    if (do_push && !rst) begin
      mem_q[wptr_q] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + PtrW'(1);
      if (do_pop)  rptr_q <= rptr_q + PtrW'(1);
      if (do_push && !do_pop)      count_q <= count_q + CntW'(1);
      else if (do_pop && !do_push) count_q <= count_q - CntW'(1);
    end
  end

endmodule

// File: rtl/ex_tracker.sv
// EX-stage trace tracker: takes elements completed by the ID tracker, times
// their stay in EX (including an optional data-memory access) and emits them.
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   counter           free-running signed cycle count
//   id_data_ready     one-cycle pulse, id_data_i valid
//   id_data_i         element from the ID tracker
//   ex_ready          EX stage accepts a new instruction
//   data_req/gnt/rvalid  core data-memory handshake
//   ex_data_o         element with ex_data filled in, held between emissions
//   ex_data_ready     one-cycle pulse, ex_data_o freshly updated
//   overflow          sticky, an input element was dropped
module ex_tracker
  import ryuki_datatypes::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic signed [31:0] counter,
  input  logic               id_data_ready,
  input  trace_output        id_data_i,
  input  logic               ex_ready,
  input  logic               data_req,
  input  logic               data_gnt,
  input  logic               data_rvalid,
  output trace_output        ex_data_o,
  output logic               ex_data_ready,
  output logic               overflow
);

  if (ADDR_WIDTH != TraceAddrWidth || DATA_WIDTH != TraceDataWidth) begin : g_width_check
    $error("ex_tracker: ADDR_WIDTH/DATA_WIDTH must match ryuki_datatypes");
  end

  ex_state_e   state_q, state_d;
  trace_output cur_q, cur_d;
  trace_output out_q, out_d;
  logic        ready_q, ready_d;
  logic        overflow_q, overflow_d;
  logic        pop, fifo_full, fifo_empty;
  trace_output head;

  trace_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH),
    .elem_t    (trace_output)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (id_data_ready),
    .wdata(id_data_i),
    .pop  (pop),
    .rdata(head),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    out_d   = out_q;
    ready_d = 1'b0;
    pop     = 1'b0;
    unique case (state_q)
      EXECUTE_START: begin
        if (!fifo_empty) begin
          pop                      = 1'b1;
          cur_d                    = head;
          cur_d.ex_data            = '0;
          cur_d.wb_data            = '0;
          cur_d.ex_data.time_start = head.id_data.time_end + 32'sd1;
          if (head.pass_through) begin
            out_d         = head;
            out_d.ex_data = '0;
            out_d.wb_data = '0;
            ready_d       = 1'b1;
          end else begin
            state_d = EXECUTE_END;
          end
        end
      end
      EXECUTE_END: begin
        // Grant wins over a same-cycle rvalid; the response is awaited in MEM_WAIT.
        if (data_req && data_gnt) begin
          cur_d.ex_data.mem_access   = 1'b1;
          cur_d.ex_data.mem_gnt_time = counter;
          state_d                    = MEM_WAIT;
        end else if (ex_ready) begin
          out_d                  = cur_q;
          out_d.ex_data.time_end = counter - 32'sd1;
          ready_d                = 1'b1;
          state_d                = EXECUTE_START;
        end
      end
      MEM_WAIT: begin
        if (data_rvalid) begin
          out_d                  = cur_q;
          out_d.ex_data.time_end = counter;
          ready_d                = 1'b1;
          state_d                = EXECUTE_START;
        end
      end
      default: state_d = EXECUTE_START;
    endcase
    overflow_d = overflow_q | (id_data_ready & fifo_full & ~pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= EXECUTE_START;
      cur_q      <= '0;
      out_q      <= '0;
      ready_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_q      <= cur_d;
      out_q      <= out_d;
      ready_q    <= ready_d;
      overflow_q <= overflow_d;
    end
  end

  assign ex_data_o     = out_q;
  assign ex_data_ready = ready_q;
  assign overflow      = overflow_q;

endmodule

// File: tb/tb_ex_tracker.sv
// Bench for ex_tracker: directed scenarios followed by randomized traffic, all
// checked every cycle against a transaction-level reference model.
module tb_ex_tracker;
  import ryuki_datatypes::*;

  localparam int unsigned Depth = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic signed [31:0] counter;
  logic               id_data_ready;
  trace_output        id_data_i;
  logic               ex_ready;
  logic               data_req, data_gnt, data_rvalid;
  trace_output        ex_data_o;
  logic               ex_data_ready;
  logic               overflow;

  int checks   = 0;
  int failures = 0;

  // Reference model state: pending queue plus the element currently in EX.
  trace_output mq[$];
  trace_output m_cur;
  bit          m_busy, m_waiting;
  trace_output exp_out;
  bit          exp_ready, exp_ovf;
  logic [31:0] emitted[$];

  always #5 clk = ~clk;

  ex_tracker #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .FIFO_DEPTH(Depth)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .counter      (counter),
    .id_data_ready(id_data_ready),
    .id_data_i    (id_data_i),
    .ex_ready     (ex_ready),
    .data_req     (data_req),
    .data_gnt     (data_gnt),
    .data_rvalid  (data_rvalid),
    .ex_data_o    (ex_data_o),
    .ex_data_ready(ex_data_ready),
    .overflow     (overflow)
  );

  function automatic trace_output make_elem(input logic [31:0] tag,
                                            input logic signed [31:0] id_end, input logic pt);
    trace_output e;
    e.addr                 = tag;
    e.data                 = $urandom;
    e.pass_through         = pt;
    e.if_data.time_start   = $urandom;
    e.if_data.time_end     = $urandom;
    e.id_data.time_start   = $urandom;
    e.id_data.time_end     = id_end;
    e.ex_data.time_start   = $urandom;
    e.ex_data.time_end     = $urandom;
    e.ex_data.mem_access   = 1'($urandom);
    e.ex_data.mem_gnt_time = $urandom;
    e.wb_data.time_start   = $urandom;
    e.wb_data.time_end     = $urandom;
    return e;
  endfunction

  // Apply this cycle's inputs to the model, as they will be seen at the next edge.
  task automatic model_step();
    int          size_before;
    bit          popped;
    trace_output e;
    exp_ready = 1'b0;
    if (rst) begin
      mq.delete();
      m_busy    = 1'b0;
      m_waiting = 1'b0;
      exp_out   = '0;
      exp_ovf   = 1'b0;
      return;
    end
    size_before = mq.size();
    popped      = 1'b0;
    if (!m_busy) begin
      if (size_before > 0) begin
        e      = mq.pop_front();
        popped = 1'b1;
        if (e.pass_through) begin
          exp_out         = e;
          exp_out.ex_data = '0;
          exp_out.wb_data = '0;
          exp_ready       = 1'b1;
        end else begin
          m_cur                    = e;
          m_cur.ex_data            = '0;
          m_cur.wb_data            = '0;
          m_cur.ex_data.time_start = e.id_data.time_end + 32'sd1;
          m_busy                   = 1'b1;
          m_waiting                = 1'b0;
        end
      end
    end else if (!m_waiting) begin
      if (data_req && data_gnt) begin
        m_cur.ex_data.mem_access   = 1'b1;
        m_cur.ex_data.mem_gnt_time = counter;
        m_waiting                  = 1'b1;
      end else if (ex_ready) begin
        exp_out                  = m_cur;
        exp_out.ex_data.time_end = counter - 32'sd1;
        exp_ready                = 1'b1;
        m_busy                   = 1'b0;
      end
    end else if (data_rvalid) begin
      exp_out                  = m_cur;
      exp_out.ex_data.time_end = counter;
      exp_ready                = 1'b1;
      m_busy                   = 1'b0;
      m_waiting                = 1'b0;
    end
    if (id_data_ready) begin
      if (size_before < int'(Depth) || popped) mq.push_back(id_data_i);
      else exp_ovf = 1'b1;
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    counter = counter + 32'sd1;
    checks++;
    assert (ex_data_ready === exp_ready) else begin
      failures++;
      $error("FAIL ready @%0d: got %b want %b", counter, ex_data_ready, exp_ready);
    end
    checks++;
    assert (overflow === exp_ovf) else begin
      failures++;
      $error("FAIL overflow @%0d: got %b want %b", counter, overflow, exp_ovf);
    end
    checks++;
    assert (ex_data_o === exp_out) else begin
      failures++;
      $error("FAIL data @%0d: got %h want %h", counter, ex_data_o, exp_out);
    end
    if (ex_data_ready === 1'b1) emitted.push_back(ex_data_o.addr);
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      failures++;
      $error("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  task automatic idle();
    id_data_ready = 1'b0;
    ex_ready      = 1'b0;
    data_req      = 1'b0;
    data_gnt      = 1'b0;
    data_rvalid   = 1'b0;
  endtask

  task automatic run_until(input int c);
    while (counter < c) cycle();
  endtask

  task automatic push_one(input trace_output e);
    id_data_ready = 1'b1;
    id_data_i     = e;
    cycle();
    id_data_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] exp_tags[6];
    counter   = 0;
    id_data_i = '0;
    m_cur     = '0;
    exp_out   = '0;
    m_busy    = 1'b0;
    m_waiting = 1'b0;
    exp_ovf   = 1'b0;
    idle();

    // Reset, with a push attempt that must be ignored.
    rst           = 1'b1;
    id_data_ready = 1'b1;
    id_data_i     = make_elem(32'hdead, 5, 1'b0);
    cycle();
    id_data_ready = 1'b0;
    cycle();
    rst = 1'b0;
    chk("reset_ready", 32'(ex_data_ready), 0);
    chk("reset_ovf", 32'(overflow), 0);
    chk("reset_addr", ex_data_o.addr, 0);

    // Plain instruction: time_end=10, ex_ready at counter 14.
    run_until(11);
    push_one(make_elem(1, 10, 1'b0));
    run_until(14);
    ex_ready = 1'b1;
    cycle();
    ex_ready = 1'b0;
    chk("plain_ready@15", 32'(ex_data_ready), 1);
    chk("plain_tstart", ex_data_o.ex_data.time_start, 11);
    chk("plain_tend", ex_data_o.ex_data.time_end, 13);
    chk("plain_wb", ex_data_o.wb_data.time_end, 0);

    // Pass-through pushed at 20, emitted at 22 without ex_ready.
    run_until(20);
    push_one(make_elem(2, 19, 1'b1));
    cycle();
    chk("pt_ready@22", 32'(ex_data_ready), 1);
    chk("pt_addr", ex_data_o.addr, 2);
    chk("pt_ex_tstart", ex_data_o.ex_data.time_start, 0);
    chk("pt_ex_gnt", ex_data_o.ex_data.mem_gnt_time, 0);

    // Load: grant at 30, rvalid at 33.
    run_until(27);
    push_one(make_elem(3, 25, 1'b0));
    run_until(30);
    data_req = 1'b1;
    data_gnt = 1'b1;
    cycle();
    idle();
    run_until(33);
    data_rvalid = 1'b1;
    cycle();
    data_rvalid = 1'b0;
    chk("load_ready", 32'(ex_data_ready), 1);
    chk("load_mem", 32'(ex_data_o.ex_data.mem_access), 1);
    chk("load_gnt", ex_data_o.ex_data.mem_gnt_time, 30);
    chk("load_tend", ex_data_o.ex_data.time_end, 33);
    chk("load_tstart", ex_data_o.ex_data.time_start, 26);

    // Grant and rvalid together: grant only, response on the following cycle.
    run_until(40);
    push_one(make_elem(4, 38, 1'b0));
    run_until(42);
    data_req    = 1'b1;
    data_gnt    = 1'b1;
    data_rvalid = 1'b1;
    cycle();
    idle();
    chk("gnt_rv_no_emit", 32'(ex_data_ready), 0);
    data_rvalid = 1'b1;
    cycle();
    data_rvalid = 1'b0;
    chk("gnt_rv_ready", 32'(ex_data_ready), 1);
    chk("gnt_rv_gnt", ex_data_o.ex_data.mem_gnt_time, 42);
    chk("gnt_rv_tend", ex_data_o.ex_data.time_end, 43);

    // Overflow: blocker held in EX, then five pushes into a depth-4 queue.
    run_until(50);
    emitted.delete();
    push_one(make_elem(9, 49, 1'b0));
    cycle();
    for (int i = 0; i < 5; i++) push_one(make_elem(32'(11 + i), 60, 1'b0));
    chk("ovf_set", 32'(overflow), 1);
    ex_ready = 1'b1;
    for (int i = 0; i < 30; i++) cycle();
    ex_ready    = 1'b0;
    exp_tags[0] = 9;
    exp_tags[1] = 11;
    exp_tags[2] = 12;
    exp_tags[3] = 13;
    exp_tags[4] = 14;
    chk("ovf_count", emitted.size(), 5);
    for (int i = 0; i < 5; i++)
      chk("ovf_order", (i < emitted.size()) ? emitted[i] : 32'hffff_ffff, exp_tags[i]);

    // Reset while waiting for memory data.
    push_one(make_elem(20, 80, 1'b0));
    cycle();
    data_req = 1'b1;
    data_gnt = 1'b1;
    cycle();
    idle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("rst_mw_ovf", 32'(overflow), 0);
    chk("rst_mw_addr", ex_data_o.addr, 0);
    emitted.delete();
    data_rvalid = 1'b1;
    cycle();
    data_rvalid = 1'b0;
    for (int i = 0; i < 3; i++) cycle();
    chk("rst_mw_no_emit", emitted.size(), 0);
    push_one(make_elem(21, 90, 1'b0));
    cycle();
    ex_ready = 1'b1;
    cycle();
    ex_ready = 1'b0;
    chk("rst_mw_next_ready", 32'(ex_data_ready), 1);
    chk("rst_mw_next_addr", ex_data_o.addr, 21);
    chk("rst_mw_next_tstart", ex_data_o.ex_data.time_start, 91);

    // Push into a full queue in the same cycle as a pop.
    emitted.delete();
    push_one(make_elem(30, 100, 1'b0));
    cycle();
    for (int i = 0; i < 4; i++) push_one(make_elem(32'(31 + i), 100, 1'b0));
    ex_ready = 1'b1;
    cycle();
    ex_ready = 1'b0;
    push_one(make_elem(35, 100, 1'b0));
    chk("full_pop_ovf", 32'(overflow), 0);
    ex_ready = 1'b1;
    for (int i = 0; i < 30; i++) cycle();
    ex_ready = 1'b0;
    chk("full_pop_count", emitted.size(), 6);
    chk("full_pop_last", (emitted.size() == 6) ? emitted[5] : 32'hffff_ffff, 35);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      rst           = ($urandom_range(199) == 0);
      id_data_ready = ($urandom_range(2) == 0);
      id_data_i     = make_elem($urandom, $urandom, ($urandom_range(3) == 0));
      ex_ready      = 1'($urandom);
      data_req      = ($urandom_range(2) == 0);
      data_gnt      = 1'($urandom);
      data_rvalid   = ($urandom_range(2) == 0);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
